// File: rtl/bram_tdp.sv
// True dual-port synchronous RAM, single clock, one-cycle registered read on each port.
// Port B wins a same-address write collision; a cross-port read returns the old word.
module bram_tdp #(
  parameter int width_a   = 8,
  parameter int widthad_a = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clock_a,
  input  logic                 clock_b,
  input  logic [widthad_a-1:0] address_a,
  input  logic [width_a-1:0]   data_a,
  input  logic                 wren_a,
  input  logic                 enable_a,
  output logic [width_a-1:0]   q_a,
  input  logic [widthad_a-1:0] address_b,
  input  logic [width_a-1:0]   data_b,
  input  logic                 wren_b,
  input  logic                 enable_b,
  output logic [width_a-1:0]   q_b
);
  localparam int DEPTH = 1 << widthad_a;

  logic [width_a-1:0] mem_q [0:DEPTH-1];
  logic [width_a-1:0] q_a_q, q_a_d;
  logic [width_a-1:0] q_b_q, q_b_d;

  // Legacy per-port clock pins are kept only for pin compatibility.
  logic unused_clk_pins;
  assign unused_clk_pins = clock_a ^ clock_b;

  // Same-port write-through; the array read sees pre-edge contents.
  always_comb begin
    q_a_d = q_a_q;
    q_b_d = q_b_q;
    if (enable_a) q_a_d = wren_a ? data_a : mem_q[address_a];
    if (enable_b) q_b_d = wren_b ? data_b : mem_q[address_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  // Port B's write is issued last so it takes the address on a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enable_a && wren_a) mem_q[address_a] <= data_a;
      if (enable_b && wren_b) mem_q[address_b] <= data_b;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;
endmodule

// File: tb/tb_bram_tdp.sv
// Self-checking bench for bram_tdp: directed cases plus a random collision-heavy phase,
// expected q values queued from a behavioural model when each cycle is driven.
module tb_bram_tdp;
  localparam int W  = 8;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address_a, address_b;
  logic [W-1:0]  data_a, data_b, q_a, q_b;
  logic          wren_a, wren_b, enable_a, enable_b;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] mem_m [0:(1<<AW)-1];
  logic [W-1:0] qa_m, qb_m;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  always #5 clk = ~clk;

  bram_tdp #(.width_a(W), .widthad_a(AW)) dut (
    .clk(clk), .reset(reset), .clock_a(clk), .clock_b(clk),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .enable_a(enable_a), .q_a(q_a),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .enable_b(enable_b), .q_b(q_b)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, queue model expectation, compare 1ns after posedge.
  task automatic step(input string tag, input logic rst,
                      input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [W-1:0] da,
                      input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [W-1:0] db);
    logic [W-1:0] ea_v, eb_v;
    @(negedge clk);
    reset = rst;
    enable_a = ea; wren_a = wa; address_a = aa; data_a = da;
    enable_b = eb; wren_b = wb; address_b = ab; data_b = db;
    if (rst) begin
      qa_m = '0;
      qb_m = '0;
    end else begin
      if (ea) qa_m = wa ? da : mem_m[aa];
      if (eb) qb_m = wb ? db : mem_m[ab];
      if (ea && wa) mem_m[aa] = da;
      if (eb && wb) mem_m[ab] = db;
    end
    exp_a_q.push_back(qa_m);
    exp_b_q.push_back(qb_m);
    @(posedge clk);
    #1;
    ea_v = exp_a_q.pop_front();
    eb_v = exp_b_q.pop_front();
    chk({tag, "_qa"}, q_a, ea_v);
    chk({tag, "_qb"}, q_b, eb_v);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
    qa_m = '0; qb_m = '0;
    reset = 1'b1;
    enable_a = 0; wren_a = 0; address_a = '0; data_a = '0;
    enable_b = 0; wren_b = 0; address_b = '0; data_b = '0;

    // reset state
    step("rst0", 1, 0,0,0,0, 0,0,0,0);
    step("rst1", 1, 0,0,0,0, 0,0,0,0);
    chk("rst_qa0", q_a, 8'h00);
    chk("rst_qb0", q_b, 8'h00);

    // A writes, B reads one cycle behind
    step("t1w0", 0, 1,1,14'h0000,8'hA5, 0,0,0,0);
    step("t1w1", 0, 1,1,14'h3FFF,8'h5A, 1,0,14'h0000,0);
    chk("t1_b0000", q_b, 8'hA5);
    step("t1w2", 0, 1,1,14'h1200,8'h3C, 1,0,14'h3FFF,0);
    chk("t1_b3fff", q_b, 8'h5A);
    step("t1r2", 0, 0,0,0,0, 1,0,14'h1200,0);
    chk("t1_b1200", q_b, 8'h3C);

    // cross-port read during write returns old data
    step("t2pre", 0, 1,1,14'h0010,8'h11, 0,0,0,0);
    step("t2col", 0, 1,0,14'h0010,0, 1,1,14'h0010,8'h77);
    chk("t2_qa_old", q_a, 8'h11);
    chk("t2_qb_wt", q_b, 8'h77);
    step("t2rd", 0, 1,0,14'h0010,0, 0,0,0,0);
    chk("t2_qa_new", q_a, 8'h77);

    // same-address dual write: B wins
    step("t3col", 0, 1,1,14'h0020,8'h01, 1,1,14'h0020,8'h02);
    chk("t3_qa_wt", q_a, 8'h01);
    chk("t3_qb_wt", q_b, 8'h02);
    step("t3rd", 0, 1,0,14'h0020,0, 1,0,14'h0020,0);
    chk("t3_qa", q_a, 8'h02);
    chk("t3_qb", q_b, 8'h02);

    // disabled port neither writes nor updates q
    step("t4pre", 0, 1,1,14'h0030,8'h00, 0,0,0,0);
    step("t4ld", 0, 1,0,14'h0010,0, 0,0,0,0);
    step("t4dis", 0, 0,1,14'h0030,8'hFF, 0,0,0,0);
    chk("t4_hold", q_a, 8'h77);
    step("t4rd", 0, 1,0,14'h0030,0, 0,0,0,0);
    chk("t4_mem", q_a, 8'h00);

    // reset suppresses writes and clears q, storage kept
    step("t5p0", 0, 0,0,0,0, 1,1,14'h0041,8'h99);
    step("t5p1", 0, 0,0,0,0, 1,1,14'h0040,8'h00);
    step("t5rst", 1, 1,0,14'h0041,0, 1,1,14'h0040,8'hEE);
    chk("t5_qa0", q_a, 8'h00);
    chk("t5_qb0", q_b, 8'h00);
    step("t5rd", 0, 1,0,14'h0040,0, 1,0,14'h0041,0);
    chk("t5_40", q_a, 8'h00);
    chk("t5_41", q_b, 8'h99);

    // back-to-back B reads
    for (int i = 0; i < 4; i++) step("t6w", 0, 0,0,0,0, 1,1,14'h0100 + 14'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) begin
      step("t6r", 0, 0,0,0,0, 1,0,14'h0100 + 14'(i), 0);
      chk("t6_seq", q_b, 8'(i + 1));
    end

    // random traffic on a small window to force collisions
    for (int i = 0; i < 300; i++)
      step("rnd", ($urandom_range(0, 29) == 0),
           1'($urandom), 1'($urandom), 14'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom), 1'($urandom), 14'($urandom_range(0, 7)), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
